// File: rtl/cfg_serial_loader_if.sv
// ---------------------------------------------------------------------------
// cfg_serial_loader_if
// Bundle of request, preset-table and 3-wire serial signals for
// cfg_serial_loader.
//   next_i       : request to send preset[idx], then advance idx
//   repeat_i     : request to resend preset[idx-1], idx unchanged
//   preset_idx_o : index presented to the external preset table
//   cfg_word_i   : table word for preset_idx_o
//   cfg_ena_o    : serial enable to the DUT
//   cfg_sclk_o   : serial clock to the DUT
//   cfg_data_o   : serial data to the DUT
//   busy_o       : transfer in progress
//   done_o       : one-cycle end-of-transfer pulse
// slave  = loader view, master = driver/table view.
// ---------------------------------------------------------------------------
interface cfg_serial_loader_if #(
  parameter int unsigned CFG_WIDTH = 57,
  parameter int unsigned IDX_W     = 5
);
  logic                 next_i;
  logic                 repeat_i;
  logic [IDX_W-1:0]     preset_idx_o;
  logic [CFG_WIDTH-1:0] cfg_word_i;
  logic                 cfg_ena_o;
  logic                 cfg_sclk_o;
  logic                 cfg_data_o;
  logic                 busy_o;
  logic                 done_o;

  modport slave (
    input  next_i,
    input  repeat_i,
    input  cfg_word_i,
    output preset_idx_o,
    output cfg_ena_o,
    output cfg_sclk_o,
    output cfg_data_o,
    output busy_o,
    output done_o
  );

  modport master (
    output next_i,
    output repeat_i,
    output cfg_word_i,
    input  preset_idx_o,
    input  cfg_ena_o,
    input  cfg_sclk_o,
    input  cfg_data_o,
    input  busy_o,
    input  done_o
  );
endinterface

// File: rtl/cfg_serial_loader.sv
// ---------------------------------------------------------------------------
// cfg_serial_loader
// Fetches a preset configuration word from an external table by index and
// shifts it out over a 3-wire (enable / sclk / data) serial interface.
// Supports a sclk divider, a repeat-last-preset request and selectable bit
// order, with busy/done status.
// Ports:
//   clk   : system clock
//   reset : synchronous, active-high reset
//   bus   : cfg_serial_loader_if.slave (requests, table, serial pins, status)
// ---------------------------------------------------------------------------
module cfg_serial_loader #(
  parameter int unsigned CFG_WIDTH   = 57,
  parameter int unsigned NUM_PRESETS = 18,
  parameter int unsigned IDX_W       = 5,
  parameter int unsigned SCLK_DIV    = 1,
  parameter int unsigned MSB_FIRST   = 0
) (
  input logic              clk,
  input logic              reset,
  cfg_serial_loader_if.slave bus
);

  localparam int unsigned CNT_W = $clog2(CFG_WIDTH);
  localparam int unsigned DIV_W = (SCLK_DIV > 1) ? $clog2(SCLK_DIV) : 1;

  localparam logic [2:0] S_IDLE = 3'd0;
  localparam logic [2:0] S_LOAD = 3'd1;
  localparam logic [2:0] S_ENA  = 3'd2;
  localparam logic [2:0] S_HI   = 3'd3;
  localparam logic [2:0] S_LO   = 3'd4;
  localparam logic [2:0] S_DONE = 3'd5;

  // Registered state
  logic [2:0]           r_state;
  logic [IDX_W-1:0]     r_idx;
  logic                 r_mode_rep;
  logic [CFG_WIDTH-1:0] r_shreg;
  logic [CNT_W-1:0]     r_bit_cnt;
  logic [DIV_W-1:0]     r_div_cnt;
  logic                 r_next_q;
  logic                 r_rep_q;

  // Registered outputs
  logic [IDX_W-1:0]     r_pidx;
  logic                 r_ena;
  logic                 r_sclk;
  logic                 r_busy;
  logic                 r_done;

  // Next-state values
  logic [2:0]           w_state_nxt;
  logic [IDX_W-1:0]     w_idx_nxt;
  logic                 w_mode_rep_nxt;
  logic [CFG_WIDTH-1:0] w_shreg_nxt;
  logic [CNT_W-1:0]     w_bit_cnt_nxt;
  logic [DIV_W-1:0]     w_div_cnt_nxt;
  logic [IDX_W-1:0]     w_pidx_nxt;
  logic                 w_ena_nxt;
  logic                 w_sclk_nxt;
  logic                 w_busy_nxt;
  logic                 w_done_nxt;

  logic                 w_next_edge;
  logic                 w_rep_edge;
  logic                 w_div_last;
  logic                 w_bit_last;
  logic [IDX_W-1:0]     w_idx_prev;
  logic [IDX_W-1:0]     w_idx_succ;
  logic [CFG_WIDTH-1:0] w_shreg_shifted;
  logic                 w_data;

  // Rising-edge detection on the debounced request levels
  assign w_next_edge = bus.next_i & ~r_next_q;
  assign w_rep_edge  = bus.repeat_i & ~r_rep_q;

  assign w_div_last  = (r_div_cnt == DIV_W'(SCLK_DIV - 1));
  assign w_bit_last  = (r_bit_cnt == CNT_W'(CFG_WIDTH - 1));

  // Modulo-NUM_PRESETS neighbours of the current index
  assign w_idx_prev  = (r_idx == '0) ? IDX_W'(NUM_PRESETS - 1) : r_idx - IDX_W'(1);
  assign w_idx_succ  = (r_idx == IDX_W'(NUM_PRESETS - 1)) ? '0 : r_idx + IDX_W'(1);

  // Shift moves the already-sent bit out so the next one lands on the data tap
  assign w_shreg_shifted = (MSB_FIRST != 0) ? {r_shreg[CFG_WIDTH-2:0], 1'b0}
                                            : {1'b0, r_shreg[CFG_WIDTH-1:1]};
  assign w_data = (MSB_FIRST != 0) ? r_shreg[CFG_WIDTH-1] : r_shreg[0];

  // Next-state and next-output logic
  always_comb begin
    w_state_nxt    = r_state;
    w_idx_nxt      = r_idx;
    w_mode_rep_nxt = r_mode_rep;
    w_shreg_nxt    = r_shreg;
    w_bit_cnt_nxt  = r_bit_cnt;
    w_div_cnt_nxt  = r_div_cnt;

    case (r_state)
      S_IDLE: begin
        // next wins when both edges coincide
        if (w_next_edge) begin
          w_state_nxt    = S_LOAD;
          w_mode_rep_nxt = 1'b0;
        end else if (w_rep_edge) begin
          w_state_nxt    = S_LOAD;
          w_mode_rep_nxt = 1'b1;
        end
      end
      S_LOAD: begin
        w_shreg_nxt   = bus.cfg_word_i;
        w_bit_cnt_nxt = '0;
        w_div_cnt_nxt = '0;
        w_state_nxt   = S_ENA;
      end
      S_ENA: begin
        if (w_div_last) begin
          w_div_cnt_nxt = '0;
          w_state_nxt   = S_HI;
        end else begin
          w_div_cnt_nxt = r_div_cnt + DIV_W'(1);
        end
      end
      S_HI: begin
        if (w_div_last) begin
          w_div_cnt_nxt = '0;
          w_state_nxt   = S_LO;
        end else begin
          w_div_cnt_nxt = r_div_cnt + DIV_W'(1);
        end
      end
      S_LO: begin
        if (w_div_last) begin
          w_div_cnt_nxt = '0;
          w_shreg_nxt   = w_shreg_shifted;
          w_bit_cnt_nxt = r_bit_cnt + CNT_W'(1);
          w_state_nxt   = w_bit_last ? S_DONE : S_HI;
        end else begin
          w_div_cnt_nxt = r_div_cnt + DIV_W'(1);
        end
      end
      S_DONE: begin
        if (!r_mode_rep) begin
          w_idx_nxt = w_idx_succ;
        end
        w_state_nxt = S_IDLE;
      end
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase

    // Outputs are decoded from the next state so they register in step with it
    w_busy_nxt = (w_state_nxt != S_IDLE);
    w_ena_nxt  = (w_state_nxt == S_ENA) || (w_state_nxt == S_HI) || (w_state_nxt == S_LO);
    w_sclk_nxt = (w_state_nxt == S_HI);
    w_done_nxt = (w_state_nxt == S_DONE);
    w_pidx_nxt = ((w_state_nxt == S_LOAD) && w_mode_rep_nxt) ? w_idx_prev : w_idx_nxt;
  end

  // State and output registers; edge registers track inputs even in reset
  always_ff @(posedge clk) begin
    r_next_q <= bus.next_i;
    r_rep_q  <= bus.repeat_i;
    if (reset) begin
      r_state    <= S_IDLE;
      r_idx      <= '0;
      r_mode_rep <= 1'b0;
      r_shreg    <= '0;
      r_bit_cnt  <= '0;
      r_div_cnt  <= '0;
      r_pidx     <= '0;
      r_ena      <= 1'b0;
      r_sclk     <= 1'b0;
      r_busy     <= 1'b0;
      r_done     <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      r_idx      <= w_idx_nxt;
      r_mode_rep <= w_mode_rep_nxt;
      r_shreg    <= w_shreg_nxt;
      r_bit_cnt  <= w_bit_cnt_nxt;
      r_div_cnt  <= w_div_cnt_nxt;
      r_pidx     <= w_pidx_nxt;
      r_ena      <= w_ena_nxt;
      r_sclk     <= w_sclk_nxt;
      r_busy     <= w_busy_nxt;
      r_done     <= w_done_nxt;
    end
  end

  assign bus.preset_idx_o = r_pidx;
  assign bus.cfg_ena_o    = r_ena;
  assign bus.cfg_sclk_o   = r_sclk;
  assign bus.cfg_data_o   = w_data;
  assign bus.busy_o       = r_busy;
  assign bus.done_o       = r_done;

endmodule
